// File: rtl/dds_tune_ctrl_pkg.sv
// Shared DDS retune definitions: FSM encoding, error codes, bus widths.
package dds_tune_ctrl_pkg;

  localparam int M_W = 9;
  localparam int F_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BUSY_HI,
    S_BUSY_LO,
    S_PLL_RST,
    S_WAIT_LOCK,
    S_COMMIT,
    S_FAIL
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BADREQ  = 2'd1,
    ERR_BUSY_TO = 2'd2,
    ERR_LOCK_TO = 2'd3
  } err_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dds_tune_ctrl_if.sv
// Retune bus: host request, PLL reconfig handshake, lock input, NCO word and status.
interface dds_tune_ctrl_if;
  import dds_tune_ctrl_pkg::*;

  logic           req_valid;
  logic           req_ready;
  logic [M_W-1:0] req_m;
  logic [F_W-1:0] req_nco_f;
  logic           update;
  logic [M_W-1:0] counter_data;
  logic           busy;
  logic           pll_reset;
  logic           locked;
  logic [F_W-1:0] nco_f;
  logic           tune_done;
  logic           tune_err;
  logic [1:0]     err_code;
  logic [1:0]     retry_cnt;

  // host / PLL side
  modport master (
    output req_valid, req_m, req_nco_f, busy, locked,
    input  req_ready, update, counter_data, pll_reset, nco_f,
           tune_done, tune_err, err_code, retry_cnt
  );

  // retune controller side
  modport slave (
    input  req_valid, req_m, req_nco_f, busy, locked,
    output req_ready, update, counter_data, pll_reset, nco_f,
           tune_done, tune_err, err_code, retry_cnt
  );

endinterface

// File: rtl/dds_tune_ctrl_lock_sync.sv
// Two-flop synchroniser for the asynchronous PLL lock indication.
module dds_lock_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // meta -> q shift; both clear to 0 so lock is never assumed out of reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dds_tune_ctrl.sv
// DDS retune sequencer: reprograms the PLL M-count, resets the PLL, waits for
// a stable lock, then commits the NCO word so PLL and NCO change together.
module dds_tune_ctrl
  import dds_tune_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 1 << 20,
  parameter int BUSY_TIMEOUT = 1024,
  parameter int MAX_RETRY    = 3
) (
  input logic            clk,
  input logic            reset,
  dds_tune_ctrl_if.slave bus
);

  // One down-counter serves every timed state; loading N-1 and expiring at
  // zero keeps it at clog2 of the largest timeout.
  localparam int TMR_MAX = max_int(max_int(LOCK_TIMEOUT, BUSY_TIMEOUT), RST_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam int STB_W   = $clog2(LOCK_STABLE + 1);

  localparam logic [TMR_W-1:0] BUSY_LD  = TMR_W'(BUSY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] RST_LD   = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LD  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
  localparam logic [1:0]       RETRY_LIM = 2'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [STB_W-1:0] stab_q, stab_d;
  logic [1:0]       retry_q;
  logic [F_W-1:0]   f_q;
  logic [F_W-1:0]   nco_q;
  logic [M_W-1:0]   cd_q;
  logic [1:0]       fail_q;
  logic [1:0]       err_q;
  logic             terr_q;

  logic             lock_s;
  logic             accept, bad_req, set_fail, retry_inc, give_up;
  logic [1:0]       fail_code;

  dds_lock_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.locked),
    .q     (lock_s)
  );

  // Next state, shared timer, lock stability count and datapath strobes
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    stab_d    = stab_q;
    accept    = 1'b0;
    bad_req   = 1'b0;
    set_fail  = 1'b0;
    fail_code = ERR_NONE;
    retry_inc = 1'b0;
    give_up   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (bus.req_m == '0) bad_req = 1'b1;
          else                 state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_BUSY_HI;
        tmr_d   = BUSY_LD;
      end
      S_BUSY_HI: begin
        // level check: busy already high on entry passes straight through
        if (bus.busy) begin
          state_d = S_BUSY_LO;
          tmr_d   = BUSY_LD;
        end else if (tmr_q == '0) begin
          state_d   = S_FAIL;
          set_fail  = 1'b1;
          fail_code = ERR_BUSY_TO;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_BUSY_LO: begin
        if (!bus.busy) begin
          state_d = S_PLL_RST;
          tmr_d   = RST_LD;
        end else if (tmr_q == '0) begin
          state_d   = S_FAIL;
          set_fail  = 1'b1;
          fail_code = ERR_BUSY_TO;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_PLL_RST: begin
        if (tmr_q == '0) begin
          state_d = S_WAIT_LOCK;
          tmr_d   = LOCK_LD;
          stab_d  = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        stab_d = lock_s ? stab_q + STB_W'(1) : '0;
        // lock is tested first so it wins a tie with the timeout
        if (lock_s && stab_q == STB_LAST) begin
          state_d = S_COMMIT;
        end else if (tmr_q == '0) begin
          state_d   = S_FAIL;
          set_fail  = 1'b1;
          fail_code = ERR_LOCK_TO;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_COMMIT: state_d = S_IDLE;
      S_FAIL: begin
        if (retry_q < RETRY_LIM) begin
          retry_inc = 1'b1;
          state_d   = S_LOAD;
        end else begin
          give_up = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, timers and latched request/status registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      stab_q  <= '0;
      retry_q <= '0;
      f_q     <= '0;
      nco_q   <= '0;
      cd_q    <= '0;
      fail_q  <= ERR_NONE;
      err_q   <= ERR_NONE;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      stab_q  <= stab_d;
      terr_q  <= bad_req | give_up;
      if (accept) begin
        f_q     <= bus.req_nco_f;
        err_q   <= ERR_NONE;
        retry_q <= '0;
      end
      if (accept && !bad_req) cd_q   <= bus.req_m;
      if (bad_req)            err_q  <= ERR_BADREQ;
      if (set_fail)           fail_q <= fail_code;
      if (give_up)            err_q  <= fail_q;
      if (retry_inc)          retry_q <= retry_q + 2'd1;
      // new word appears together with tune_done in COMMIT
      if (state_q == S_WAIT_LOCK && state_d == S_COMMIT) nco_q <= f_q;
    end
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.update       = (state_q == S_LOAD);
  assign bus.pll_reset    = (state_q == S_PLL_RST);
  assign bus.tune_done    = (state_q == S_COMMIT);
  assign bus.tune_err     = terr_q;
  assign bus.counter_data = cd_q;
  assign bus.nco_f        = nco_q;
  assign bus.err_code     = err_q;
  assign bus.retry_cnt    = retry_q;

endmodule
